uart_rx_module: RTL

Asynchronous serial receiver for 8N1 frames, LSB first, idle-high line. It is the receive-side counterpart of the team's 9600-baud UART transmitter and shares its clock and reset. Sampling uses a 16x oversampled tick generated internally from `clk`. Each received byte is presented on a parallel output together with a one-cycle valid pulse, and framing errors are flagged.

---
 rtl/uart_rx_module.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_module.sv
// 8N1 asynchronous receiver with an internal 16x oversample tick, a double-flop
// input synchronizer, a one-clock data-valid pulse and a framing-error pulse.
module uart_rx_module #(
   parameter int unsigned CLKS_PER_TICK = 326,
   parameter int unsigned OVERSAMPLE    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_rx,
   output logic [7:0] parallel_rx_out,
   output logic       rx_done,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int unsigned DIV_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_TICK - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t           state, state_n;
   logic             rx_m, rx_s;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [OS_W-1:0]  tick_cnt, tick_cnt_n;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [7:0]       shreg, shreg_n;
   logic [7:0]       data_n;
   logic             done_n, ferr_n;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= serial_rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= IDLE;
         tick_cnt        <= '0;
         bit_cnt         <= '0;
         shreg           <= '0;
         parallel_rx_out <= '0;
         rx_done         <= 1'b0;
         frame_err       <= 1'b0;
      end else begin
         state           <= state_n;
         tick_cnt        <= tick_cnt_n;
         bit_cnt         <= bit_cnt_n;
         shreg           <= shreg_n;
         parallel_rx_out <= data_n;
         rx_done         <= done_n;
         frame_err       <= ferr_n;
      end
   end

   // All sequencing advances only on oversample ticks, so pulses last one clk.
   always_comb begin
      state_n    = state;
      tick_cnt_n = tick_cnt;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      data_n     = parallel_rx_out;
      done_n     = 1'b0;
      ferr_n     = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_n    = START;
                  tick_cnt_n = '0;
               end
            end
            START: begin
               if (tick_cnt == OS_MID) begin
                  if (rx_s) begin
                     state_n = IDLE;
                  end else begin
                     state_n    = DATA;
                     tick_cnt_n = '0;
                     bit_cnt_n  = '0;
                  end
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tick_cnt == OS_LAST) begin
                  shreg_n    = {rx_s, shreg[7:1]};
                  tick_cnt_n = '0;
                  if (bit_cnt == 3'd7) begin
                     state_n = STOP;
                  end else begin
                     bit_cnt_n = bit_cnt + 1'b1;
                  end
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
            STOP: begin
               if (tick_cnt == OS_LAST) begin
                  tick_cnt_n = '0;
                  if (rx_s) begin
                     data_n  = shreg;
                     done_n  = 1'b1;
                     state_n = IDLE;
                  end else begin
                     ferr_n  = 1'b1;
                     state_n = WAIT_IDLE;
                  end
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
            WAIT_IDLE: begin
               if (rx_s) begin
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign rx_busy = (state != IDLE);

endmodule
